// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that lets N masters share one 32-bit memory-bus slave port.
// A watchdog force-completes transactions the slave never acknowledges, returning ERR_RDATA.
module mem_bus_arbiter #(
   parameter int unsigned N_MASTERS      = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF,
   localparam int unsigned GW            = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_MASTERS-1:0]      m_valid,
   output logic [N_MASTERS-1:0]      m_ready,
   input  logic [4*N_MASTERS-1:0]    m_wstrb,
   input  logic [32*N_MASTERS-1:0]   m_addr,
   input  logic [32*N_MASTERS-1:0]   m_wdata,
   output logic [31:0]               m_rdata,
   output logic                      s_valid,
   input  logic                      s_ready,
   output logic [3:0]                s_wstrb,
   output logic [31:0]               s_addr,
   output logic [31:0]               s_wdata,
   input  logic [31:0]               s_rdata,
   output logic [GW-1:0]             grant,
   output logic                      busy,
   output logic                      timeout
);

   localparam int unsigned CW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GRANT_RST = GW'(N_MASTERS - 1);
   localparam logic          WDOG_EN   = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t                 state, state_nxt;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic [N_MASTERS-1:0]   m_ready_nxt;
   logic [31:0]            m_rdata_nxt;
   logic                   s_valid_nxt;
   logic [3:0]             s_wstrb_nxt;
   logic [31:0]            s_addr_nxt;
   logic [31:0]            s_wdata_nxt;
   logic [GW-1:0]          grant_nxt;
   logic                   timeout_nxt;

   logic                   found;
   logic [GW-1:0]          win;
   logic [3:0]             win_wstrb;
   logic [31:0]            win_addr;
   logic [31:0]            win_wdata;
   logic [N_MASTERS-1:0]   grant_onehot;

   // Round-robin search: masters above the last grant first, then wrap to 0..grant.
   always_comb begin
      found     = 1'b0;
      win       = '0;
      win_wstrb = '0;
      win_addr  = '0;
      win_wdata = '0;
      for (int i = 0; i < int'(N_MASTERS); i++) begin
         if (!found && m_valid[i] && (i > int'(grant))) begin
            found     = 1'b1;
            win       = GW'(i);
            win_wstrb = m_wstrb[4*i +: 4];
            win_addr  = m_addr[32*i +: 32];
            win_wdata = m_wdata[32*i +: 32];
         end
      end
      for (int i = 0; i < int'(N_MASTERS); i++) begin
         if (!found && m_valid[i]) begin
            found     = 1'b1;
            win       = GW'(i);
            win_wstrb = m_wstrb[4*i +: 4];
            win_addr  = m_addr[32*i +: 32];
            win_wdata = m_wdata[32*i +: 32];
         end
      end
   end

   always_comb begin
      grant_onehot = '0;
      for (int i = 0; i < int'(N_MASTERS); i++) begin
         grant_onehot[i] = (grant == GW'(i));
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      m_ready_nxt = '0;
      m_rdata_nxt = m_rdata;
      s_valid_nxt = s_valid;
      s_wstrb_nxt = s_wstrb;
      s_addr_nxt  = s_addr;
      s_wdata_nxt = s_wdata;
      grant_nxt   = grant;
      timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               s_wstrb_nxt = win_wstrb;
               s_addr_nxt  = win_addr;
               s_wdata_nxt = win_wdata;
               grant_nxt   = win;
               s_valid_nxt = 1'b1;
               cnt_nxt     = '0;
               state_nxt   = BUSY;
            end else begin
               s_valid_nxt = 1'b0;
            end
         end
         BUSY: begin
            // A real acknowledge takes precedence over the watchdog firing in the same cycle.
            if (s_ready) begin
               m_rdata_nxt = s_rdata;
               m_ready_nxt = grant_onehot;
               s_valid_nxt = 1'b0;
               state_nxt   = DONE;
            end else if (WDOG_EN && (cnt == CNT_LAST)) begin
               m_rdata_nxt = ERR_RDATA;
               m_ready_nxt = grant_onehot;
               timeout_nxt = 1'b1;
               s_valid_nxt = 1'b0;
               state_nxt   = DONE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt   = IDLE;
            s_valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         m_ready <= '0;
         m_rdata <= '0;
         s_valid <= 1'b0;
         s_wstrb <= '0;
         s_addr  <= '0;
         s_wdata <= '0;
         grant   <= GRANT_RST;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         m_ready <= m_ready_nxt;
         m_rdata <= m_rdata_nxt;
         s_valid <= s_valid_nxt;
         s_wstrb <= s_wstrb_nxt;
         s_addr  <= s_addr_nxt;
         s_wdata <= s_wdata_nxt;
         grant   <= grant_nxt;
         timeout <= timeout_nxt;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two masters, 4-cycle watchdog, scripted slave whose read data is addr ^ 0x11.
module tb_mem_bus_arbiter;

   localparam int          N   = 2;
   localparam int          TO  = 4;
   localparam logic [31:0] ERR = 32'hFFFF_FFFF;

   logic            clk;
   logic            reset;
   logic [N-1:0]    m_valid;
   logic [N-1:0]    m_ready;
   logic [4*N-1:0]  m_wstrb;
   logic [32*N-1:0] m_addr;
   logic [32*N-1:0] m_wdata;
   logic [31:0]     m_rdata;
   logic            s_valid;
   logic            s_ready;
   logic [3:0]      s_wstrb;
   logic [31:0]     s_addr;
   logic [31:0]     s_wdata;
   logic [31:0]     s_rdata;
   logic [0:0]      grant;
   logic            busy;
   logic            timeout;

   int n_cmp  = 0;
   int n_fail = 0;
   bit check_en = 1'b0;

   mem_bus_arbiter #(
      .N_MASTERS(N),
      .TIMEOUT_CYCLES(TO),
      .ERR_RDATA(ERR)
   ) dut (
      .clk(clk),
      .reset(reset),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_wstrb(m_wstrb),
      .m_addr(m_addr),
      .m_wdata(m_wdata),
      .m_rdata(m_rdata),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_wstrb(s_wstrb),
      .s_addr(s_addr),
      .s_wdata(s_wdata),
      .s_rdata(s_rdata),
      .grant(grant),
      .busy(busy),
      .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave acks after s_valid has been high ack_delay cycles, then keeps ready high one extra cycle.
   bit   ack_en    = 1'b1;
   int   ack_delay = 1;
   int   hcnt      = 0;
   logic prev_ack  = 1'b0;
   logic base_ack;
   assign base_ack = ack_en && s_valid && (hcnt == ack_delay);
   assign s_ready  = base_ack || prev_ack;
   assign s_rdata  = s_valid ? (s_addr ^ 32'h0000_0011) : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      hcnt     <= s_valid ? hcnt + 1 : 0;
      prev_ack <= base_ack;
   end

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   // Transaction-level model: a request occupies the bus until the slave acks or TO cycles pass.
   bit          md_active = 1'b0;
   bit          md_done   = 1'b0;
   int          md_age    = 0;
   int          e_grant   = N - 1;
   logic [N-1:0] e_ready  = '0;
   logic [31:0] e_rdata   = '0;
   logic [31:0] e_addr    = '0;
   logic [31:0] e_wdata   = '0;
   logic [3:0]  e_wstrb   = '0;
   logic        e_sv      = 1'b0;
   logic        e_to      = 1'b0;
   int          tb_pick;
   assign tb_pick = rr_pick(m_valid, e_grant);

   always @(posedge clk) begin
      if (reset) begin
         md_active <= 1'b0;
         md_done   <= 1'b0;
         md_age    <= 0;
         e_grant   <= N - 1;
         e_ready   <= '0;
         e_rdata   <= '0;
         e_addr    <= '0;
         e_wdata   <= '0;
         e_wstrb   <= '0;
         e_sv      <= 1'b0;
         e_to      <= 1'b0;
      end else if (md_done) begin
         md_done <= 1'b0;
         e_ready <= '0;
         e_to    <= 1'b0;
      end else if (md_active) begin
         if (ack_en && (md_age == ack_delay)) begin
            md_active        <= 1'b0;
            md_done          <= 1'b1;
            e_sv             <= 1'b0;
            e_ready          <= '0;
            e_ready[e_grant] <= 1'b1;
            e_rdata          <= e_addr ^ 32'h0000_0011;
         end else if (md_age == TO - 1) begin
            md_active        <= 1'b0;
            md_done          <= 1'b1;
            e_sv             <= 1'b0;
            e_ready          <= '0;
            e_ready[e_grant] <= 1'b1;
            e_rdata          <= ERR;
            e_to             <= 1'b1;
         end else begin
            md_age <= md_age + 1;
         end
      end else if (tb_pick >= 0) begin
         md_active <= 1'b1;
         md_age    <= 0;
         e_sv      <= 1'b1;
         e_grant   <= tb_pick;
         e_addr    <= m_addr[32*tb_pick +: 32];
         e_wdata   <= m_wdata[32*tb_pick +: 32];
         e_wstrb   <= m_wstrb[4*tb_pick +: 4];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (check_en) begin
         checkOutput("model_m_ready", 32'(m_ready), 32'(e_ready));
         checkOutput("model_s_valid", 32'(s_valid), 32'(e_sv));
         checkOutput("model_busy", 32'(busy), 32'(md_active || md_done));
         checkOutput("model_timeout", 32'(timeout), 32'(e_to));
         checkOutput("model_grant", 32'(grant), e_grant);
         checkOutput("model_s_addr", s_addr, e_addr);
         checkOutput("model_s_wstrb", 32'(s_wstrb), 32'(e_wstrb));
         checkOutput("model_s_wdata", s_wdata, e_wdata);
         if (e_ready != '0) checkOutput("model_m_rdata", m_rdata, e_rdata);
      end
   end

   task automatic applyStimulus(input int idx, input logic [3:0] wstrb, input logic [31:0] addr,
                                input logic [31:0] wdata);
      m_wstrb[4*idx +: 4]   = wstrb;
      m_addr[32*idx +: 32]  = addr;
      m_wdata[32*idx +: 32] = wdata;
      m_valid[idx]          = 1'b1;
   endtask

   task automatic waitReady(input int idx, input int limit);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < limit && !ok; c++) begin
         @(negedge clk);
         if (m_ready[idx]) ok = 1'b1;
      end
      if (!ok) checkOutput("wait_m_ready", 32'(m_ready[idx]), 32'd1);
   endtask

   int order[4];
   int nfound;

   initial begin
      reset   = 1'b1;
      m_valid = '0;
      m_wstrb = '0;
      m_addr  = '0;
      m_wdata = '0;
      @(negedge clk);
      check_en = 1'b1;
      @(negedge clk);
      checkOutput("rst_m_ready", 32'(m_ready), 32'd0);
      checkOutput("rst_m_rdata", m_rdata, 32'd0);
      checkOutput("rst_s_valid", 32'(s_valid), 32'd0);
      checkOutput("rst_s_addr", s_addr, 32'd0);
      checkOutput("rst_s_wstrb", 32'(s_wstrb), 32'd0);
      checkOutput("rst_s_wdata", s_wdata, 32'd0);
      checkOutput("rst_grant", 32'(grant), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_timeout", 32'(timeout), 32'd0);
      reset = 1'b0;

      $display("[TB] single read");
      applyStimulus(0, 4'h0, 32'h0000_0010, 32'h0);
      @(negedge clk);
      checkOutput("rd_s_valid_t1", 32'(s_valid), 32'd1);
      checkOutput("rd_s_addr_t1", s_addr, 32'h10);
      checkOutput("rd_grant_t1", 32'(grant), 32'd0);
      @(negedge clk);
      checkOutput("rd_m_ready_t2", 32'(m_ready), 32'd0);
      @(negedge clk);
      checkOutput("rd_m_ready_t3", 32'(m_ready), 32'b01);
      checkOutput("rd_m_rdata_t3", m_rdata, 32'h1);
      m_valid[0] = 1'b0;
      @(negedge clk);
      checkOutput("rd_m_ready_t4", 32'(m_ready), 32'd0);
      checkOutput("rd_busy_t4", 32'(busy), 32'd0);

      $display("[TB] single write");
      ack_delay = 2;
      applyStimulus(1, 4'b0001, 32'h0000_0020, 32'h0000_0001);
      @(negedge clk);
      checkOutput("wr_s_addr", s_addr, 32'h20);
      checkOutput("wr_s_wstrb", 32'(s_wstrb), 32'h1);
      checkOutput("wr_s_wdata", s_wdata, 32'h1);
      checkOutput("wr_grant", 32'(grant), 32'd1);
      waitReady(1, 20);
      checkOutput("wr_s_valid_done", 32'(s_valid), 32'd0);
      m_valid[1] = 1'b0;
      @(negedge clk);
      checkOutput("wr_m_ready_after", 32'(m_ready), 32'd0);

      $display("[TB] contention");
      reset = 1'b1;
      ack_delay = 1;
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(0, 4'h0, 32'h0000_0100, 32'h0);
      applyStimulus(1, 4'hF, 32'h0000_0200, 32'hCAFE_0001);
      nfound = 0;
      for (int c = 0; c < 60 && nfound < 4; c++) begin
         @(negedge clk);
         if (m_ready != '0) begin
            order[nfound] = m_ready[1] ? 1 : 0;
            nfound++;
         end
      end
      m_valid = '0;
      checkOutput("rr_count", 32'(nfound), 32'd4);
      checkOutput("rr_order0", 32'(order[0]), 32'd0);
      checkOutput("rr_order1", 32'(order[1]), 32'd1);
      checkOutput("rr_order2", 32'(order[2]), 32'd0);
      checkOutput("rr_order3", 32'(order[3]), 32'd1);

      $display("[TB] watchdog timeout");
      ack_en = 1'b0;
      @(negedge clk);
      applyStimulus(0, 4'h0, 32'h0000_0030, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checkOutput("to_m_ready_early", 32'(m_ready), 32'd0);
         checkOutput("to_timeout_early", 32'(timeout), 32'd0);
      end
      @(negedge clk);
      checkOutput("to_m_ready", 32'(m_ready), 32'b01);
      checkOutput("to_timeout", 32'(timeout), 32'd1);
      checkOutput("to_m_rdata", m_rdata, 32'hFFFF_FFFF);
      m_valid[0] = 1'b0;
      @(negedge clk);
      checkOutput("to_timeout_clear", 32'(timeout), 32'd0);
      ack_en = 1'b1;
      ack_delay = 1;
      applyStimulus(1, 4'h0, 32'h0000_0040, 32'h0);
      waitReady(1, 20);
      checkOutput("after_to_rdata", m_rdata, 32'h51);
      checkOutput("after_to_timeout", 32'(timeout), 32'd0);
      m_valid[1] = 1'b0;
      @(negedge clk);

      $display("[TB] ack on timeout boundary");
      ack_delay = 3;
      applyStimulus(0, 4'h0, 32'h0000_0050, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checkOutput("bd_m_ready_early", 32'(m_ready), 32'd0);
      end
      @(negedge clk);
      checkOutput("bd_m_ready", 32'(m_ready), 32'b01);
      checkOutput("bd_timeout", 32'(timeout), 32'd0);
      checkOutput("bd_m_rdata", m_rdata, 32'h41);
      m_valid[0] = 1'b0;
      @(negedge clk);

      $display("[TB] reset mid-busy");
      ack_en = 1'b0;
      applyStimulus(1, 4'h0, 32'h0000_0060, 32'h0);
      @(negedge clk);
      checkOutput("rb_s_valid", 32'(s_valid), 32'd1);
      checkOutput("rb_grant", 32'(grant), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(0, 4'h0, 32'h0000_0070, 32'h0);
      @(negedge clk);
      checkOutput("rb_s_valid_rst", 32'(s_valid), 32'd0);
      checkOutput("rb_m_ready_rst", 32'(m_ready), 32'd0);
      checkOutput("rb_grant_rst", 32'(grant), 32'd1);
      reset = 1'b0;
      ack_en = 1'b1;
      ack_delay = 1;
      @(negedge clk);
      checkOutput("rb_post_s_valid", 32'(s_valid), 32'd1);
      checkOutput("rb_post_grant", 32'(grant), 32'd0);
      checkOutput("rb_post_s_addr", s_addr, 32'h70);
      waitReady(0, 20);
      m_valid[0] = 1'b0;
      waitReady(1, 20);
      checkOutput("rb_m1_rdata", m_rdata, 32'h71);
      m_valid[1] = 1'b0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      n_fail++;
      $display("[TB] FAIL global_watchdog: simulation did not complete in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "[TB] stopped by global watchdog");
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one peripheral memory-bus slave port (valid/ready/wstrb/addr/wdata/rdata, 32-bit) among N requesting masters, e.g. CPU and a DMA engine.
- Arbitration is round-robin. The winning request is registered and presented to the slave. The response is returned to the winning master only.
- A watchdog completes any transaction the slave never acknowledges, so an unmapped or hung peripheral cannot stall the bus.
- Sits between the masters and the peripheral address decoder / register blocks.

Parameters:
- N_MASTERS, 2, number of requesters (1..8).
- TIMEOUT_CYCLES, 255, cycles in BUSY without s_ready before forced completion; 0 disables the watchdog.
- ERR_RDATA, 32'hFFFF_FFFF, rdata returned on a timed-out transaction.

Ports:
- clk  in  1  bus clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m_valid  in  N_MASTERS  per-master request.
- m_ready  out  N_MASTERS  per-master completion pulse, one cycle.
- m_wstrb  in  4*N_MASTERS  byte strobes; master i uses [4i+3:4i]; 0 means read.
- m_addr  in  32*N_MASTERS  address; master i uses [32i+31:32i].
- m_wdata  in  32*N_MASTERS  write data; master i uses [32i+31:32i].
- m_rdata  out  32  read data, shared; valid only in the cycle a m_ready bit is high.
- s_valid  out  1  request to the slave.
- s_ready  in  1  slave acknowledge.
- s_wstrb  out  4  registered strobes of the granted master.
- s_addr  out  32  registered address of the granted master.
- s_wdata  out  32  registered write data of the granted master.
- s_rdata  in  32  slave read data, sampled when s_ready=1.
- grant  out  clog2(N_MASTERS) (min 1)  index of the master currently or last served.
- busy  out  1  high in BUSY and DONE.
- timeout  out  1  one-cycle pulse, coincident with m_ready, on forced completion.

Behaviour:
- Reset values: m_ready=0, m_rdata=0, s_valid=0, s_wstrb=0, s_addr=0, s_wdata=0, grant=N_MASTERS-1, busy=0, timeout=0, state=IDLE, watchdog counter=0.
- Reset asserted mid-transaction aborts it. No m_ready is issued. The slave sees s_valid=0 on the next cycle.
- FSM states: IDLE, BUSY, DONE.
- IDLE, arbitration:
  - If any m_valid bit is high, pick the first set bit searching from (grant+1) mod N_MASTERS upward, wrapping around.
  - Register that master's wstrb/addr/wdata into s_*, set grant, set s_valid=1, clear the counter, go to BUSY.
  - If no m_valid bit is high, stay in IDLE with s_valid=0.
  - After reset, master 0 therefore has highest priority.
- BUSY:
  - s_valid=1 and s_* are held stable.
  - m_valid changes from any master, including deassertion by the granted master, are ignored until completion.
  - If s_ready=1: m_rdata<=s_rdata, m_ready[grant]<=1 for one cycle, s_valid<=0, go to DONE.
  - Else if TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1: m_rdata<=ERR_RDATA, m_ready[grant]<=1, timeout<=1, s_valid<=0, go to DONE.
  - Else the counter increments.
  - When s_ready and the timeout condition occur in the same cycle, s_ready wins: normal completion, no timeout pulse.
- DONE:
  - Lasts exactly one cycle with s_valid=0. This lets a slave with registered ready (ready<=valid) drop ready before the next request.
  - Then go to IDLE. Any s_ready seen in DONE is ignored.
- Masters must deassert m_valid the cycle after their m_ready.
  - A master still asserting m_valid in IDLE is treated as a new request.
  - That master is lowest priority, because grant already points at it.
- Latency with a registered-ready slave:
  - m_valid seen in IDLE at cycle t.
  - s_valid high at t+1.
  - s_ready at t+2.
  - m_ready and m_rdata at t+3.
  - Earliest next grant at t+4.
- At most one m_ready bit is ever high. m_ready bits are never high in IDLE.
- N_MASTERS=1 degenerates to a registered pass-through with watchdog; grant stays 0.

Test Plan:
- Single read: master 0 requests addr 0x0000_0010, wstrb 0; slave acks 1 cycle after s_valid with s_rdata 0x1 → m_ready[0] high at t+3, m_rdata=0x1, m_ready[1] stays 0.
- Single write: master 1 requests wstrb 4'b0001, wdata 0x1 → s_addr/s_wdata/s_wstrb match master 1 and stay stable during BUSY; m_ready[1] pulses once; s_valid is low in DONE.
- Contention: both masters assert continuously from reset → grants alternate 0,1,0,1 over 4 transactions; each m_ready is exactly one cycle wide.
- Timeout: TIMEOUT_CYCLES=4, slave never acks → m_ready and timeout pulse together exactly 4 cycles after s_valid rises; m_rdata=0xFFFF_FFFF; the next request is served normally.
- Ack on the timeout boundary: s_ready arrives in the same cycle the counter hits 3 with TIMEOUT_CYCLES=4 → normal completion with slave data, timeout stays 0.
- Reset mid-BUSY: assert reset while s_valid=1 → the next cycle has s_valid=0, no m_ready, grant=N_MASTERS-1, and master 0 wins the first post-reset arbitration.
